// File: rtl/sar_adc_ctrl.sv
// rtl/sar_adc_ctrl.sv - successive-approximation ADC controller with 2-flop comparator sync.
// Optional SAR_AVG_EN: average four back-to-back conversions per start.
module sar_adc_ctrl #(
  parameter int WIDTH         = 8,
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cmp,
  output logic             sample_o,
  output logic [WIDTH-1:0] dac_code,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int IW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SAMPLE, BIT, DONE} state_t;

  state_t           state;
  logic             cmp_m;
  logic             cmp_s;
  logic [15:0]      cnt;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] kept;

`ifdef SAR_AVG_EN
  logic [1:0]       pass;
  logic [WIDTH+1:0] acc;
  logic [WIDTH+1:0] acc_sum;
  assign acc_sum = acc + {2'b00, kept};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_m <= 1'b0;
      cmp_s <= 1'b0;
    end else begin
      cmp_m <= cmp;
      cmp_s <= cmp_m;
    end
  end

  // Trial bit survives only if the comparator says Vin >= Vdac.
  always_comb begin
    mask      = '0;
    mask[idx] = 1'b1;
    kept      = cmp_s ? dac_code : (dac_code & ~mask);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sample_o <= 1'b0;
      dac_code <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      cnt      <= '0;
      idx      <= '0;
`ifdef SAR_AVG_EN
      pass     <= '0;
      acc      <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= SAMPLE;
            sample_o <= 1'b1;
            busy     <= 1'b1;
            cnt      <= '0;
            dac_code <= '0;
`ifdef SAR_AVG_EN
            pass     <= '0;
            acc      <= '0;
`endif
          end
        end
        SAMPLE: begin
          if (cnt == 16'(SAMPLE_CYCLES - 1)) begin
            cnt      <= '0;
            sample_o <= 1'b0;
            state    <= BIT;
            idx      <= IW'(WIDTH - 1);
            dac_code <= {1'b1, {(WIDTH-1){1'b0}}};
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        BIT: begin
          if (cnt == 16'(SETTLE_CYCLES - 1)) begin
            cnt <= '0;
            if (idx != '0) begin
              idx      <= idx - IW'(1);
              dac_code <= kept | (mask >> 1);
            end else begin
              dac_code <= '0;
`ifdef SAR_AVG_EN
              acc  <= acc_sum;
              pass <= pass + 2'd1;
              if (pass == 2'd3) begin
                result <= acc_sum[WIDTH+1:2];
                done   <= 1'b1;
                state  <= DONE;
              end else begin
                state    <= SAMPLE;
                sample_o <= 1'b1;
              end
`else
              result <= kept;
              done   <= 1'b1;
              state  <= DONE;
`endif
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// tb/tb_sar_adc_ctrl.sv - scoreboard bench for sar_adc_ctrl with an ideal comparator model.
module tb_sar_adc_ctrl;
  localparam int W  = 8;
  localparam int SC = 4;
  localparam int ST = 4;
`ifdef SAR_AVG_EN
  localparam int NCONV = 4;
`else
  localparam int NCONV = 1;
`endif
  localparam int LAT = NCONV * (SC + W * ST) + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         cmp;
  logic         sample_o;
  logic         busy;
  logic         done;
  logic [W-1:0] dac_code;
  logic [W-1:0] result;
  logic [W-1:0] target = '0;

  int           checks = 0;
  int           failures = 0;
  int           done_cnt = 0;
  logic [W-1:0] exp_q[$];

  assign cmp = (target >= dac_code);

  always #5 clk = ~clk;

  sar_adc_ctrl #(.WIDTH(W), .SAMPLE_CYCLES(SC), .SETTLE_CYCLES(ST)) dut (
    .clk(clk), .rst(rst), .start(start), .cmp(cmp), .sample_o(sample_o),
    .dac_code(dac_code), .busy(busy), .done(done), .result(result)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Independent SAR walk: the k-th trial code for an ideal comparator.
  function automatic int trial_code(input int t, input int k);
    int code = 0;
    int tr = 0;
    for (int b = W - 1; b >= W - 1 - k; b--) begin
      tr = code | (1 << b);
      if (t >= tr) code = tr;
    end
    return tr;
  endfunction

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (exp_q.size() == 0) check("spurious_done", 1, 0);
      else check("result", int'(result), int'(exp_q.pop_front()));
    end
  end

  task automatic run_conv(input logic [W-1:0] t0, input logic [W-1:0] t1,
                          input int pulse_at, input bit chk_trials);
    int n = 0;
    int samp = 0;
    int rises = 0;
    int base = done_cnt;
    logic prev_s = 1'b0;
    logic [W-1:0] e;
    if (NCONV == 1) e = t0;
    else e = W'((2 * int'(t0) + 2 * int'(t1)) / 4);
    exp_q.push_back(e);
    target = t0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    while (!done && n < LAT + 20) begin
      @(negedge clk);
      n++;
      if (sample_o) samp++;
      if (sample_o && !prev_s) begin
        target = (rises % 2 == 0) ? t0 : t1;
        rises++;
      end
      prev_s = sample_o;
      if (chk_trials && n > SC && n <= SC + W * ST)
        check("trial", int'(dac_code), trial_code(int'(t0), (n - SC - 1) / ST));
      start = (n == pulse_at);
    end
    start = 1'b0;
    check("latency", n, LAT);
    check("busy_done_cycle", int'(busy), 1);
    check("sample_cycles", samp, NCONV * SC);
    @(negedge clk);
    check("done_pulse", int'(done), 0);
    check("busy_after", int'(busy), 0);
    check("dac_idle", int'(dac_code), 0);
    check("done_count", done_cnt - base, 1);
  endtask

  task automatic run_b2b();
    logic [W-1:0] tg[3] = '{8'h10, 8'hEF, 8'h33};
    int base = done_cnt;
    int n;
    for (int i = 0; i < 3; i++) exp_q.push_back(tg[i]);
    target = tg[0];
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!done && n < 2 * LAT + 20);
      check("b2b_gap", n, (i == 0) ? LAT : LAT + 1);
      if (i < 2) target = tg[i + 1];
      else start = 1'b0;
    end
    repeat (5) @(negedge clk);
    check("b2b_done_count", done_cnt - base, 3);
    check("b2b_busy_end", int'(busy), 0);
  endtask

  task automatic run_reset_abort();
    int base;
    target = 8'h5A;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    base = done_cnt;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_sample", int'(sample_o), 0);
    check("rst_dac", int'(dac_code), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_result", int'(result), 0);
    repeat (LAT + 5) @(negedge clk);
    check("rst_no_done", done_cnt - base, 0);
    check("rst_idle_busy", int'(busy), 0);
    check("rst_result_held", int'(result), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("init_sample", int'(sample_o), 0);
    check("init_dac", int'(dac_code), 0);
    check("init_busy", int'(busy), 0);
    check("init_done", int'(done), 0);
    check("init_result", int'(result), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_conv(8'h00, 8'h00, -1, 1'b0);
    run_conv(8'hFF, 8'hFF, -1, 1'b0);
    run_conv(8'h80, 8'h80, -1, 1'b0);
    run_conv(8'h5A, 8'h5A, -1, 1'b1);
    run_conv(8'h37, 8'h37, 10, 1'b0);
    run_b2b();
`ifdef SAR_AVG_EN
    run_conv(8'h40, 8'h43, -1, 1'b0);
`endif
    run_reset_abort();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
